regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Write-side producer for the 32x32 register file's single write port (RegWrite/WriteReg/WriteData).
- Accepts register write-back requests from two sources, the ALU path and the multi-cycle load path, and buffers them in an in-order FIFO.
- Drains the FIFO one write per cycle onto the register file port.
- Exports per-register pending flags so issue logic can stall reads of registers with writes still in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- mem_valid  input  1  load path has a write-back request.
- mem_reg  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load data.
- mem_ready  output  1  load request accepted this cycle.
- alu_valid  input  1  ALU path has a write-back request.
- alu_reg  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- wr_stall  input  1  register file port unavailable; hold the drain this cycle.
- RegWrite  output  1  registered write enable to the register file.
- WriteReg  output  ADDR_W  registered write index.
- WriteData  output  DATA_W  registered write data.
- query_reg1  input  ADDR_W  register probed by issue logic.
- query_reg2  input  ADDR_W  register probed by issue logic.
- pend1  output  1  query_reg1 has a pending write.
- pend2  output  1  query_reg2 has a pending write.
- count  output  clog2(DEPTH+1)  occupied entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (reset=0, asynchronous) forces count=0, RegWrite=0, WriteReg=0, WriteData=0, and invalidates all entries. Reset mid-operation discards all queued and in-flight writes; nothing is emitted after release until a new request is accepted.
- Enqueue: at most one request per cycle. The load path has priority.
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid.
  - Both ready signals are combinational from registered count and the valid inputs.
  - The handshake completes on a rising edge where valid && ready are both 1.
- A request whose destination is register 0 completes its handshake but is dropped: no entry, count unchanged. Register 0 stays hardwired zero.
- Drain: on each rising edge with count>0 and wr_stall=0, the head entry pops and RegWrite<=1, WriteReg<=head.reg, WriteData<=head.data. Otherwise RegWrite<=0, and WriteReg/WriteData hold their previous values.
- Latency: a request accepted at edge N into an empty queue drives RegWrite=1 after edge N+1; the register file stores it at edge N+2.
- Simultaneous enqueue and dequeue on the same edge: count unchanged, order preserved. Ready is computed from the pre-edge count, so a full queue refuses requests even while draining.
- Ordering is strict FIFO. Two writes to the same register land in acceptance order, so the last one wins.
- Pointers are ADDR-free log2(DEPTH)-bit read/write indices that wrap modulo DEPTH. count never exceeds DEPTH or goes below 0.
- pendX = (query_regX != 0) && (any valid FIFO entry has reg == query_regX, or (RegWrite && WriteReg == query_regX)). pendX is combinational. An entry accepted at an edge counts as pending from that edge.
- full and empty are derived combinationally from count.

Test Plan:
- Reset release, then alu_valid=1, alu_reg=3, alu_data=0x2A for one cycle → count=1 for one cycle. Next cycle RegWrite=1, WriteReg=3, WriteData=0x2A. Following cycle RegWrite=0, empty=1.
- mem_valid and alu_valid both high with mem_reg=4/0xFFFFFFCB and alu_reg=5/0x67 → alu_ready=0 and the load is accepted first. Holding alu_valid one more cycle gets the ALU write accepted. Writes emerge as reg 4 then reg 5.
- wr_stall=1 with 4 ALU writes to regs 1..4 → full=1 and alu_ready=0 on the fifth request. Releasing wr_stall drains 1,2,3,4 on consecutive cycles with RegWrite=1 each cycle.
- alu_reg=0, alu_data=0xDEAD → alu_ready=1, count stays 0, no RegWrite pulse, pend for query 0 stays 0.
- Queue entries for reg 6 and reg 6 with query_reg1=6, query_reg2=7 → pend1=1 and pend2=0. pend1 stays 1 until the cycle after the second RegWrite to reg 6.
- Assert reset=0 asynchronously mid-clock with 3 entries queued and RegWrite=1 → RegWrite, WriteReg, WriteData and count go to 0 immediately. No further writes emerge after release.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue that merges load and ALU results onto the single register-file write port.
// Also reports which registers still have writes in flight, so issue logic can stall dependent reads.
module regfile_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mem_valid,
   input  logic [ADDR_W-1:0]            mem_reg,
   input  logic [DATA_W-1:0]            mem_data,
   output logic                         mem_ready,
   input  logic                         alu_valid,
   input  logic [ADDR_W-1:0]            alu_reg,
   input  logic [DATA_W-1:0]            alu_data,
   output logic                         alu_ready,
   input  logic                         wr_stall,
   output logic                         RegWrite,
   output logic [ADDR_W-1:0]            WriteReg,
   output logic [DATA_W-1:0]            WriteData,
   input  logic [ADDR_W-1:0]            query_reg1,
   input  logic [ADDR_W-1:0]            query_reg2,
   output logic                         pend1,
   output logic                         pend2,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] reg_q   [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   logic              take;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_reg;
   logic [DATA_W-1:0] push_data;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;

   // Writes to r0 complete the handshake but never occupy an entry.
   assign take      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
   assign push_reg  = mem_valid ? mem_reg  : alu_reg;
   assign push_data = mem_valid ? mem_data : alu_data;
   assign push      = take && (push_reg != '0);
   assign pop       = !empty && !wr_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         valid_q   <= '0;
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         RegWrite <= pop;
         if (pop) begin
            WriteReg        <= reg_q[rd_ptr];
            WriteData       <= data_q[rd_ptr];
            valid_q[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end
         // A push never targets the slot being popped: pushes are refused when full.
         if (push) begin
            reg_q[wr_ptr]   <= push_reg;
            data_q[wr_ptr]  <= push_data;
            valid_q[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && reg_q[i] == query_reg1) pend1 = 1'b1;
         if (valid_q[i] && reg_q[i] == query_reg2) pend2 = 1'b1;
      end
      // The write on the port this cycle lands at the next edge, so it is still in flight.
      if (RegWrite && WriteReg == query_reg1) pend1 = 1'b1;
      if (RegWrite && WriteReg == query_reg2) pend2 = 1'b1;
      if (query_reg1 == '0) pend1 = 1'b0;
      if (query_reg2 == '0) pend2 = 1'b0;
   end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: a vector table walked one cycle per row,
// followed by a hand-written asynchronous-reset sequence.
module tb_regfile_writeback_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, alu_valid, wr_stall;
   logic [4:0]  mem_reg, alu_reg, query_reg1, query_reg2;
   logic [31:0] mem_data, alu_data;
   logic        mem_ready, alu_ready, RegWrite, pend1, pend2, full, empty;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
      .wr_stall(wr_stall),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .query_reg1(query_reg1), .query_reg2(query_reg2), .pend1(pend1), .pend2(pend2),
      .count(count), .full(full), .empty(empty)
   );

   // Each row: inputs held for one cycle, and the outputs expected during that cycle
   // (state left by the previous rows, combinational outputs from this row's inputs).
   typedef struct {
      logic        mv;  logic [4:0] mr; logic [31:0] md;
      logic        av;  logic [4:0] ar; logic [31:0] ad;
      logic        st;  logic [4:0] q1; logic [4:0]  q2;
      logic        e_mrdy; logic e_ardy; logic [2:0] e_cnt;
      logic        e_rw;   logic [4:0] e_wr; logic [31:0] e_wd;
      logic        e_p1;   logic e_p2;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] mv, mr, md, av, ar, ad, st, q1, q2,
                      input logic [31:0] e_mrdy, e_ardy, e_cnt, e_rw, e_wr, e_wd, e_p1, e_p2);
      vec_t r;
      r.mv = mv[0]; r.mr = mr[4:0]; r.md = md;
      r.av = av[0]; r.ar = ar[4:0]; r.ad = ad;
      r.st = st[0]; r.q1 = q1[4:0]; r.q2 = q2[4:0];
      r.e_mrdy = e_mrdy[0]; r.e_ardy = e_ardy[0]; r.e_cnt = e_cnt[2:0];
      r.e_rw = e_rw[0]; r.e_wr = e_wr[4:0]; r.e_wd = e_wd;
      r.e_p1 = e_p1[0]; r.e_p2 = e_p2[0];
      vecs.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_valid = 0; mem_reg = 0; mem_data = 0;
      alu_valid = 0; alu_reg = 0; alu_data = 0;
      wr_stall = 0;
   endtask

   initial begin
      //   mv mr md          av ar ad     st q1 q2   mrdy ardy cnt rw wr wd          p1 p2
      // single ALU write to r3
      add(0, 0, 0,          0, 0, 0,     0, 3, 0,   1, 1, 0, 0, 0, 0,           0, 0);
      add(0, 0, 0,          1, 3, 'h2A,  0, 3, 0,   1, 1, 0, 0, 0, 0,           0, 0);
      add(0, 0, 0,          0, 0, 0,     0, 3, 0,   1, 1, 1, 0, 0, 0,           1, 0);
      add(0, 0, 0,          0, 0, 0,     0, 3, 0,   1, 1, 0, 1, 3, 'h2A,        1, 0);
      add(0, 0, 0,          0, 0, 0,     0, 3, 0,   1, 1, 0, 0, 3, 'h2A,        0, 0);
      // load beats ALU, ALU accepted next cycle
      add(1, 4, 'hFFFFFFCB, 1, 5, 'h67,  0, 4, 5,   1, 0, 0, 0, 3, 'h2A,        0, 0);
      add(0, 0, 0,          1, 5, 'h67,  0, 4, 5,   1, 1, 1, 0, 3, 'h2A,        1, 0);
      add(0, 0, 0,          0, 0, 0,     0, 4, 5,   1, 1, 1, 1, 4, 'hFFFFFFCB,  1, 1);
      add(0, 0, 0,          0, 0, 0,     0, 4, 5,   1, 1, 0, 1, 5, 'h67,        0, 1);
      add(0, 0, 0,          0, 0, 0,     0, 4, 5,   1, 1, 0, 0, 5, 'h67,        0, 0);
      // fill under stall, full refuses even on the draining edge
      add(0, 0, 0,          1, 1, 'h11,  1, 1, 4,   1, 1, 0, 0, 5, 'h67,        0, 0);
      add(0, 0, 0,          1, 2, 'h22,  1, 1, 4,   1, 1, 1, 0, 5, 'h67,        1, 0);
      add(0, 0, 0,          1, 3, 'h33,  1, 1, 4,   1, 1, 2, 0, 5, 'h67,        1, 0);
      add(0, 0, 0,          1, 4, 'h44,  1, 1, 4,   1, 1, 3, 0, 5, 'h67,        1, 0);
      add(0, 0, 0,          1, 7, 'h77,  1, 1, 4,   0, 0, 4, 0, 5, 'h67,        1, 1);
      add(0, 0, 0,          1, 7, 'h77,  0, 1, 4,   0, 0, 4, 0, 5, 'h67,        1, 1);
      add(0, 0, 0,          0, 0, 0,     0, 1, 4,   1, 1, 3, 1, 1, 'h11,        1, 1);
      add(0, 0, 0,          0, 0, 0,     0, 1, 4,   1, 1, 2, 1, 2, 'h22,        0, 1);
      add(0, 0, 0,          0, 0, 0,     0, 1, 4,   1, 1, 1, 1, 3, 'h33,        0, 1);
      add(0, 0, 0,          0, 0, 0,     0, 1, 4,   1, 1, 0, 1, 4, 'h44,        0, 1);
      add(0, 0, 0,          0, 0, 0,     0, 1, 4,   1, 1, 0, 0, 4, 'h44,        0, 0);
      // r0 write is accepted and dropped
      add(0, 0, 0,          1, 0, 'hDEAD, 0, 0, 0,  1, 1, 0, 0, 4, 'h44,        0, 0);
      add(0, 0, 0,          0, 0, 0,     0, 0, 0,   1, 1, 0, 0, 4, 'h44,        0, 0);
      add(0, 0, 0,          0, 0, 0,     0, 0, 0,   1, 1, 0, 0, 4, 'h44,        0, 0);
      // two writes to r6, pending until the cycle after the second port write
      add(0, 0, 0,          1, 6, 'h61,  0, 6, 7,   1, 1, 0, 0, 4, 'h44,        0, 0);
      add(0, 0, 0,          1, 6, 'h62,  0, 6, 7,   1, 1, 1, 0, 4, 'h44,        1, 0);
      add(0, 0, 0,          0, 0, 0,     0, 6, 7,   1, 1, 1, 1, 6, 'h61,        1, 0);
      add(0, 0, 0,          0, 0, 0,     0, 6, 7,   1, 1, 0, 1, 6, 'h62,        1, 0);
      add(0, 0, 0,          0, 0, 0,     0, 6, 7,   1, 1, 0, 0, 6, 'h62,        0, 0);

      idle_inputs();
      query_reg1 = 0; query_reg2 = 0;
      reset = 0;
      #2;
      chk("rst.count", 32'(count), 0);
      chk("rst.RegWrite", 32'(RegWrite), 0);
      chk("rst.WriteReg", 32'(WriteReg), 0);
      chk("rst.WriteData", WriteData, 0);
      chk("rst.empty", 32'(empty), 1);
      @(negedge clk);
      reset = 1;

      foreach (vecs[i]) begin
         @(negedge clk);
         mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
         alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
         wr_stall = vecs[i].st; query_reg1 = vecs[i].q1; query_reg2 = vecs[i].q2;
         #1;
         chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mrdy));
         chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ardy));
         chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].e_cnt == 3'd4));
         chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].e_cnt == 3'd0));
         chk($sformatf("v%0d.RegWrite", i), 32'(RegWrite), 32'(vecs[i].e_rw));
         chk($sformatf("v%0d.WriteReg", i), 32'(WriteReg), 32'(vecs[i].e_wr));
         chk($sformatf("v%0d.WriteData", i), WriteData, vecs[i].e_wd);
         chk($sformatf("v%0d.pend1", i), 32'(pend1), 32'(vecs[i].e_p1));
         chk($sformatf("v%0d.pend2", i), 32'(pend2), 32'(vecs[i].e_p2));
      end

      // Asynchronous reset with three entries queued and a write on the port.
      for (int r = 8; r < 12; r++) begin
         @(negedge clk);
         idle_inputs();
         wr_stall = 1; alu_valid = 1; alu_reg = 5'(r); alu_data = 32'(r * 'h100);
      end
      @(negedge clk);
      idle_inputs();
      query_reg1 = 9; query_reg2 = 11;
      @(posedge clk);
      #1;
      chk("ar.pre_RegWrite", 32'(RegWrite), 1);
      chk("ar.pre_WriteReg", 32'(WriteReg), 8);
      chk("ar.pre_count", 32'(count), 3);
      chk("ar.pre_pend1", 32'(pend1), 1);
      #2;
      reset = 0;
      #1;
      chk("ar.RegWrite", 32'(RegWrite), 0);
      chk("ar.WriteReg", 32'(WriteReg), 0);
      chk("ar.WriteData", WriteData, 0);
      chk("ar.count", 32'(count), 0);
      chk("ar.empty", 32'(empty), 1);
      chk("ar.pend1", 32'(pend1), 0);
      chk("ar.pend2", 32'(pend2), 0);
      @(negedge clk);
      reset = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("ar.post%0d.RegWrite", c), 32'(RegWrite), 0);
         chk($sformatf("ar.post%0d.count", c), 32'(count), 0);
      end

      // New traffic after reset comes out alone.
      @(negedge clk);
      alu_valid = 1; alu_reg = 12; alu_data = 'hC0;
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
      chk("ar.new.RegWrite", 32'(RegWrite), 1);
      chk("ar.new.WriteReg", 32'(WriteReg), 12);
      chk("ar.new.WriteData", WriteData, 'hC0);
      @(posedge clk);
      #1;
      chk("ar.new.done", 32'(RegWrite), 0);
      chk("ar.new.empty", 32'(empty), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
